// File: rtl/rob_pkg.sv
// Reorder-buffer shared types and helpers.
// Holds the ROB geometry, the per-entry state enum, the entry record and the
// age/range helpers used by the top and the retire selector.
package rob_pkg;

   localparam int unsigned INST_ID_BITS = 6;
   localparam int unsigned PRN_BITS     = 6;
   localparam int unsigned ARN_BITS     = 6;
   localparam int unsigned MAX_OPERANDS = 3;
   localparam int unsigned ROB_DEPTH    = 1 << INST_ID_BITS;

   typedef logic [INST_ID_BITS-1:0] inst_id_t;
   // Pointer with wrap bit; also wide enough to hold a full-ROB count.
   typedef logic [INST_ID_BITS:0]   rob_ptr_t;

   typedef enum logic {
      Issued    = 1'b0,
      Committed = 1'b1
   } rob_state_e;

   typedef struct packed {
      rob_state_e                             state;
      logic [63:0]                            pc;
      logic [MAX_OPERANDS-1:0]                valid;
      logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  arn;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  old_prn;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  new_prn;
   } rob_entry_t;

   // True when a is older than b, ages measured from tail modulo depth.
   function automatic logic rob_age_lt(inst_id_t a, inst_id_t b, inst_id_t tail);
      inst_id_t off_a;
      inst_id_t off_b;
      off_a = a - tail;
      off_b = b - tail;
      return off_a < off_b;
   endfunction

   // True when id lies in [tail, tail+count).
   function automatic logic rob_in_range(inst_id_t id, inst_id_t tail, rob_ptr_t count);
      inst_id_t off;
      off = id - tail;
      return {1'b0, off} < count;
   endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Retire lane selector.
// Counts leading COMMITTED entries starting at the tail, stopping at the end of
// the occupied window or at the start of the squash range, whichever is first.
// Ports:
//   states      in   state of entries tail+0 .. tail+RETIRE_WIDTH-1
//   occupancy   in   entries currently held
//   flush_limit in   entries from tail before the squash range (occupancy if none)
//   lane_valid  out  contiguous-from-lane-0 retire mask
module rob_retire_select
   import rob_pkg::*;
#(
   parameter int unsigned RETIRE_WIDTH = 2
) (
   input  rob_state_e              states [RETIRE_WIDTH],
   input  rob_ptr_t                occupancy,
   input  rob_ptr_t                flush_limit,
   output logic [RETIRE_WIDTH-1:0] lane_valid
);

   always_comb begin
      logic run;
      run        = 1'b1;
      lane_valid = '0;
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         if (run && states[k] == Committed && rob_ptr_t'(k) < occupancy &&
             rob_ptr_t'(k) < flush_limit) begin
            lane_valid[k] = 1'b1;
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rob_multi_retire.sv
// Reorder buffer with single-issue dispatch, multi-lane in-order retirement and
// a backward-walking flush that restores rename mappings one entry per cycle.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   inst_valid/inst_ready    dispatch handshake; new_inst_id is the allocated ID
//   pc, mapping_*            per-instruction record written at dispatch
//   fu_out_inst_valid/ids    completion strobes
//   retire_*, freed_prns_*   registered retirement lanes and old PRNs to free
//   start_flush(_to)         squash the given ID and everything younger
//   flush_*, reset_*, arn_reset, prn_reset
//                            registered per-entry squash notification and restore
//   stall_rename, occupancy  rename back-pressure and entry count
module rob_multi_retire
   import rob_pkg::*;
#(
   parameter int unsigned FU_COUNT     = 4,
   parameter int unsigned RETIRE_WIDTH = 2
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic                                                 inst_valid,
   output logic                                                 inst_ready,
   input  logic [63:0]                                          pc,
   input  logic [MAX_OPERANDS-1:0]                              mapping_inputs_valid,
   input  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]                mapping_inputs_arn,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                mapping_inputs_prn,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                mapping_new_prn,
   output logic [INST_ID_BITS-1:0]                              new_inst_id,
   input  logic [FU_COUNT-1:0]                                  fu_out_inst_valid,
   input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]                fu_out_inst_ids,
   output logic [RETIRE_WIDTH-1:0]                              retire_valid,
   output logic [RETIRE_WIDTH-1:0][INST_ID_BITS-1:0]            retire_inst_id,
   output logic [RETIRE_WIDTH*MAX_OPERANDS-1:0]                 freed_prns_valid,
   output logic [RETIRE_WIDTH*MAX_OPERANDS-1:0][PRN_BITS-1:0]   freed_prns,
   input  logic                                                 start_flush,
   input  logic [INST_ID_BITS-1:0]                              start_flush_to,
   output logic                                                 flush_valid,
   output logic [INST_ID_BITS-1:0]                              flush_inst_id,
   output logic [MAX_OPERANDS-1:0]                              reset_valid,
   output logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]                arn_reset,
   output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                prn_reset,
   output logic [MAX_OPERANDS-1:0]                              flush_free_valid,
   output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                flush_free_prn,
   output logic                                                 stall_rename,
   output logic [INST_ID_BITS:0]                                occupancy
);

   typedef enum logic {FlushIdle, FlushWalk} flush_st_e;

   rob_entry_t entries_q [ROB_DEPTH];
   rob_ptr_t   head_q, head_d, tail_q, tail_d;
   flush_st_e  st_q, st_d;
   inst_id_t   ptr_q, ptr_d, flush_to_q, flush_to_d;

   rob_ptr_t   count;
   inst_id_t   tail_idx, head_idx;
   logic       flushing, dispatch, start_ok, flush_active;
   inst_id_t   flush_to_eff, flush_off;
   rob_ptr_t   flush_limit;

   inst_id_t                lane_idx   [RETIRE_WIDTH];
   rob_state_e              lane_state [RETIRE_WIDTH];
   logic [RETIRE_WIDTH-1:0] lane_valid;

   assign count        = head_q - tail_q;
   assign occupancy    = count;
   assign tail_idx     = tail_q[INST_ID_BITS-1:0];
   assign head_idx     = head_q[INST_ID_BITS-1:0];
   assign new_inst_id  = head_idx;
   assign flushing     = (st_q == FlushWalk);
   assign stall_rename = start_flush || flushing;
   // count can only reach DEPTH when its top bit is set.
   assign inst_ready   = rst && !start_flush && !flushing && !count[INST_ID_BITS];
   assign dispatch     = inst_valid && inst_ready;

   // A new target is taken in IDLE, or mid-walk only if strictly older.
   assign start_ok = start_flush && rob_in_range(start_flush_to, tail_idx, count) &&
                     (!flushing || rob_age_lt(start_flush_to, flush_to_q, tail_idx));
   assign flush_to_eff = start_ok ? start_flush_to : flush_to_q;
   assign flush_active = flushing || start_ok;
   assign flush_off    = flush_to_eff - tail_idx;
   // Retirement must stop short of the squash range, including one starting now.
   assign flush_limit  = flush_active ? {1'b0, flush_off} : count;

   always_comb begin
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         lane_idx[k]   = tail_idx + inst_id_t'(k);
         lane_state[k] = entries_q[lane_idx[k]].state;
      end
   end

   rob_retire_select #(
      .RETIRE_WIDTH (RETIRE_WIDTH)
   ) u_retire_select (
      .states      (lane_state),
      .occupancy   (count),
      .flush_limit (flush_limit),
      .lane_valid  (lane_valid)
   );

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q + rob_ptr_t'($countones(lane_valid));
      st_d       = st_q;
      ptr_d      = ptr_q;
      flush_to_d = flush_to_q;
      unique case (st_q)
         FlushIdle: begin
            if (start_ok) begin
               st_d       = FlushWalk;
               ptr_d      = head_idx - inst_id_t'(1);
               flush_to_d = start_flush_to;
            end else if (dispatch) begin
               head_d = head_q + rob_ptr_t'(1);
            end
         end
         FlushWalk: begin
            flush_to_d = flush_to_eff;
            if (ptr_q == flush_to_eff) begin
               st_d   = FlushIdle;
               head_d = tail_q + {1'b0, flush_off};
            end else begin
               ptr_d = ptr_q - inst_id_t'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q           <= '0;
         tail_q           <= '0;
         st_q             <= FlushIdle;
         ptr_q            <= '0;
         flush_to_q       <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
         retire_valid     <= '0;
         retire_inst_id   <= '0;
         freed_prns_valid <= '0;
         freed_prns       <= '0;
         flush_valid      <= 1'b0;
         flush_inst_id    <= '0;
         reset_valid      <= '0;
         arn_reset        <= '0;
         prn_reset        <= '0;
         flush_free_valid <= '0;
         flush_free_prn   <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         st_q       <= st_d;
         ptr_q      <= ptr_d;
         flush_to_q <= flush_to_d;

         if (dispatch) begin
            entries_q[head_idx] <= '{state:   Issued,
                                     pc:      pc,
                                     valid:   mapping_inputs_valid,
                                     arn:     mapping_inputs_arn,
                                     old_prn: mapping_inputs_prn,
                                     new_prn: mapping_new_prn};
         end
         // The dispatch slot is never inside [tail, head), so no write conflict.
         for (int f = 0; f < FU_COUNT; f++) begin
            if (fu_out_inst_valid[f] && rob_in_range(fu_out_inst_ids[f], tail_idx, count)) begin
               entries_q[fu_out_inst_ids[f]].state <= Committed;
            end
         end

         for (int k = 0; k < RETIRE_WIDTH; k++) begin
            retire_valid[k]   <= lane_valid[k];
            retire_inst_id[k] <= lane_valid[k] ? lane_idx[k] : '0;
            for (int op = 0; op < MAX_OPERANDS; op++) begin
               freed_prns_valid[k*MAX_OPERANDS+op] <=
                  lane_valid[k] && entries_q[lane_idx[k]].valid[op];
               freed_prns[k*MAX_OPERANDS+op] <=
                  lane_valid[k] ? entries_q[lane_idx[k]].old_prn[op] : '0;
            end
         end

         if (flushing) begin
            flush_valid      <= 1'b1;
            flush_inst_id    <= ptr_q;
            reset_valid      <= entries_q[ptr_q].valid;
            arn_reset        <= entries_q[ptr_q].arn;
            prn_reset        <= entries_q[ptr_q].old_prn;
            flush_free_valid <= entries_q[ptr_q].valid;
            flush_free_prn   <= entries_q[ptr_q].new_prn;
         end else begin
            flush_valid      <= 1'b0;
            flush_inst_id    <= '0;
            reset_valid      <= '0;
            arn_reset        <= '0;
            prn_reset        <= '0;
            flush_free_valid <= '0;
            flush_free_prn   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rob_multi_retire.sv
// Directed bench for rob_multi_retire: reset, fill/drain, multi-retire,
// out-of-order completion, flush, nested flush, wrap-around, reset mid-walk.
module tb_rob_multi_retire;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic                 inst_valid, inst_ready;
   logic [63:0]          pc;
   logic [2:0]           mapping_inputs_valid;
   logic [2:0][5:0]      mapping_inputs_arn, mapping_inputs_prn, mapping_new_prn;
   logic [5:0]           new_inst_id;
   logic [3:0]           fu_out_inst_valid;
   logic [3:0][5:0]      fu_out_inst_ids;
   logic [1:0]           retire_valid;
   logic [1:0][5:0]      retire_inst_id;
   logic [5:0]           freed_prns_valid;
   logic [5:0][5:0]      freed_prns;
   logic                 start_flush;
   logic [5:0]           start_flush_to;
   logic                 flush_valid;
   logic [5:0]           flush_inst_id;
   logic [2:0]           reset_valid, flush_free_valid;
   logic [2:0][5:0]      arn_reset, prn_reset, flush_free_prn;
   logic                 stall_rename;
   logic [6:0]           occupancy;

   int n_pass  = 0;
   int n_total = 0;
   int tb_head = 0;
   int stall_cnt;

   rob_multi_retire #(
      .FU_COUNT     (4),
      .RETIRE_WIDTH (2)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .inst_valid           (inst_valid),
      .inst_ready           (inst_ready),
      .pc                   (pc),
      .mapping_inputs_valid (mapping_inputs_valid),
      .mapping_inputs_arn   (mapping_inputs_arn),
      .mapping_inputs_prn   (mapping_inputs_prn),
      .mapping_new_prn      (mapping_new_prn),
      .new_inst_id          (new_inst_id),
      .fu_out_inst_valid    (fu_out_inst_valid),
      .fu_out_inst_ids      (fu_out_inst_ids),
      .retire_valid         (retire_valid),
      .retire_inst_id       (retire_inst_id),
      .freed_prns_valid     (freed_prns_valid),
      .freed_prns           (freed_prns),
      .start_flush          (start_flush),
      .start_flush_to       (start_flush_to),
      .flush_valid          (flush_valid),
      .flush_inst_id        (flush_inst_id),
      .reset_valid          (reset_valid),
      .arn_reset            (arn_reset),
      .prn_reset            (prn_reset),
      .flush_free_valid     (flush_free_valid),
      .flush_free_prn       (flush_free_prn),
      .stall_rename         (stall_rename),
      .occupancy            (occupancy)
   );

   // Per-ID mapping record the bench dispatches and later expects back.
   function automatic logic [2:0] mmask(input int id);
      return (id % 2 == 0) ? 3'b111 : 3'b011;
   endfunction
   function automatic logic [5:0] marn(input int id, input int op);
      return 6'((id + 5 * op) % 32);
   endfunction
   function automatic logic [5:0] mold(input int id, input int op);
      return 6'((id * 3 + op) % 64);
   endfunction
   function automatic logic [5:0] mnew(input int id, input int op);
      return 6'((id + 20 * op + 7) % 64);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_comp(input logic [3:0] v, input int a, input int b, input int c,
                           input int d);
      fu_out_inst_valid  = v;
      fu_out_inst_ids[0] = 6'(a);
      fu_out_inst_ids[1] = 6'(b);
      fu_out_inst_ids[2] = 6'(c);
      fu_out_inst_ids[3] = 6'(d);
   endtask

   task automatic idle_inputs();
      inst_valid           = 1'b0;
      pc                   = '0;
      mapping_inputs_valid = '0;
      mapping_inputs_arn   = '0;
      mapping_inputs_prn   = '0;
      mapping_new_prn      = '0;
      start_flush          = 1'b0;
      start_flush_to       = '0;
      set_comp(4'b0000, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst     = 1'b1;
      tb_head = 0;
      settle();
   endtask

   task automatic dispatch(input int n);
      for (int i = 0; i < n; i++) begin
         int id;
         id                   = tb_head % 64;
         inst_valid           = 1'b1;
         pc                   = 64'h1000 + 64'(id * 4);
         mapping_inputs_valid = mmask(id);
         for (int op = 0; op < 3; op++) begin
            mapping_inputs_arn[op] = marn(id, op);
            mapping_inputs_prn[op] = mold(id, op);
            mapping_new_prn[op]    = mnew(id, op);
         end
         tick();
         tb_head++;
      end
      inst_valid = 1'b0;
   endtask

   task automatic chk_lane(input string tag, input int l, input int id);
      logic [2:0] m;
      m = mmask(id);
      check($sformatf("%s lane%0d id", tag, l), retire_inst_id[l], id);
      check($sformatf("%s lane%0d freed_v", tag, l), freed_prns_valid[l*3 +: 3], m);
      for (int op = 0; op < 3; op++)
         if (m[op]) check($sformatf("%s lane%0d freed%0d", tag, l, op), freed_prns[l*3+op],
                          mold(id, op));
   endtask

   task automatic chk_retire(input string tag, input logic [1:0] v, input int id0,
                             input int id1);
      check({tag, " retire_valid"}, retire_valid, v);
      if (v[0]) chk_lane(tag, 0, id0);
      if (v[1]) chk_lane(tag, 1, id1);
   endtask

   task automatic chk_flush(input string tag, input int id);
      check({tag, " flush_valid"}, flush_valid, 1);
      check({tag, " flush_id"}, flush_inst_id, id);
      check({tag, " reset_valid"}, reset_valid, mmask(id));
      check({tag, " free_valid"}, flush_free_valid, mmask(id));
      for (int op = 0; op < 3; op++) begin
         check($sformatf("%s arn%0d", tag, op), arn_reset[op], marn(id, op));
         check($sformatf("%s prn%0d", tag, op), prn_reset[op], mold(id, op));
         check($sformatf("%s free%0d", tag, op), flush_free_prn[op], mnew(id, op));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      // Reset state
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      check("rst ready", inst_ready, 0);
      check("rst occ", occupancy, 0);
      check("rst retire_valid", retire_valid, 0);
      check("rst retire_id", retire_inst_id, 0);
      check("rst freed_v", freed_prns_valid, 0);
      check("rst flush_valid", flush_valid, 0);
      check("rst flush_id", flush_inst_id, 0);
      check("rst reset_valid", reset_valid, 0);
      check("rst free_valid", flush_free_valid, 0);
      check("rst new_id", new_inst_id, 0);
      rst = 1'b1;
      settle();
      check("rst ready after", inst_ready, 1);
      check("rst stall", stall_rename, 0);

      // Fill / drain
      do_reset();
      dispatch(64);
      check("fill occ", occupancy, 64);
      check("fill ready", inst_ready, 0);
      check("fill new_id", new_inst_id, 0);
      inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      check("full hold occ", occupancy, 64);
      set_comp(4'b0001, 0, 0, 0, 0);
      tick();
      set_comp(4'b0000, 0, 0, 0, 0);
      check("fill commit lat", retire_valid, 0);
      tick();
      chk_retire("drain", 2'b01, 0, 0);
      check("drain occ", occupancy, 63);
      check("drain ready", inst_ready, 1);

      // Multi-retire
      do_reset();
      dispatch(5);
      set_comp(4'b0001, 4, 0, 0, 0);
      tick();
      check("multi early", retire_valid, 0);
      set_comp(4'b1111, 0, 1, 2, 3);
      tick();
      set_comp(4'b0000, 0, 0, 0, 0);
      check("multi lat", retire_valid, 0);
      tick();
      chk_retire("multi1", 2'b11, 0, 1);
      check("multi1 occ", occupancy, 3);
      tick();
      chk_retire("multi2", 2'b11, 2, 3);
      check("multi2 occ", occupancy, 1);
      tick();
      chk_retire("multi3", 2'b01, 4, 0);
      check("multi3 occ", occupancy, 0);
      tick();
      check("multi4", retire_valid, 0);

      // Out-of-order completion
      do_reset();
      dispatch(3);
      set_comp(4'b0001, 2, 0, 0, 0);
      tick();
      set_comp(4'b0000, 0, 0, 0, 0);
      tick();
      check("ooo hold", retire_valid, 0);
      set_comp(4'b0001, 0, 0, 0, 0);
      tick();
      set_comp(4'b0000, 0, 0, 0, 0);
      check("ooo lat", retire_valid, 0);
      tick();
      chk_retire("ooo id0", 2'b01, 0, 0);
      set_comp(4'b0001, 1, 0, 0, 0);
      tick();
      set_comp(4'b0000, 0, 0, 0, 0);
      check("ooo gap", retire_valid, 0);
      tick();
      chk_retire("ooo id12", 2'b11, 1, 2);
      check("ooo occ", occupancy, 0);

      // Flush
      do_reset();
      dispatch(10);
      check("flush occ0", occupancy, 10);
      start_flush    = 1'b1;
      start_flush_to = 6'd10;
      settle();
      check("oor stall", stall_rename, 1);
      tick();
      start_flush = 1'b0;
      settle();
      check("oor flush_valid", flush_valid, 0);
      check("oor stall after", stall_rename, 0);
      check("oor occ", occupancy, 10);
      start_flush    = 1'b1;
      start_flush_to = 6'd6;
      settle();
      stall_cnt = 0;
      if (stall_rename) stall_cnt++;
      check("flush ready", inst_ready, 0);
      tick();
      start_flush = 1'b0;
      settle();
      for (int k = 0; k < 4; k++) begin
         if (stall_rename) stall_cnt++;
         tick();
         chk_flush($sformatf("walk%0d", k), 9 - k);
      end
      settle();
      if (stall_rename) stall_cnt++;
      check("flush stall cycles", stall_cnt, 5);
      check("flush occ", occupancy, 6);
      check("flush head", new_inst_id, 6);
      check("flush ready after", inst_ready, 1);
      tick();
      check("flush done", flush_valid, 0);

      // Nested flush with retirement during the walk
      do_reset();
      dispatch(10);
      start_flush    = 1'b1;
      start_flush_to = 6'd6;
      set_comp(4'b1111, 0, 1, 2, 3);
      tick();
      start_flush = 1'b0;
      set_comp(4'b0001, 4, 0, 0, 0);
      check("nest e0 flush", flush_valid, 0);
      check("nest e0 retire", retire_valid, 0);
      tick();
      set_comp(4'b0000, 0, 0, 0, 0);
      chk_flush("nest 9", 9);
      chk_retire("nest r01", 2'b11, 0, 1);
      start_flush    = 1'b1;
      start_flush_to = 6'd4;
      tick();
      chk_flush("nest 8", 8);
      chk_retire("nest r23", 2'b11, 2, 3);
      start_flush_to = 6'd7;
      tick();
      start_flush = 1'b0;
      chk_flush("nest 7", 7);
      chk_retire("nest cap", 2'b00, 0, 0);
      tick();
      chk_flush("nest 6", 6);
      tick();
      chk_flush("nest 5", 5);
      tick();
      chk_flush("nest 4", 4);
      chk_retire("nest cap2", 2'b00, 0, 0);
      settle();
      check("nest occ", occupancy, 0);
      check("nest head", new_inst_id, 4);
      check("nest stall", stall_rename, 0);
      tick();
      check("nest done", flush_valid, 0);
      check("nest no retire", retire_valid, 0);

      // Wrap-around
      do_reset();
      dispatch(62);
      for (int g = 0; g < 16; g++) begin
         set_comp((g == 15) ? 4'b0011 : 4'b1111, 4 * g, 4 * g + 1, 4 * g + 2, 4 * g + 3);
         tick();
      end
      set_comp(4'b0000, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         if (occupancy == 0) break;
         tick();
      end
      check("wrap drain occ", occupancy, 0);
      check("wrap tail", new_inst_id, 62);
      dispatch(4);
      check("wrap occ", occupancy, 4);
      start_flush    = 1'b1;
      start_flush_to = 6'd63;
      set_comp(4'b0001, 62, 0, 0, 0);
      tick();
      start_flush = 1'b0;
      set_comp(4'b0000, 0, 0, 0, 0);
      check("wrap e0", flush_valid, 0);
      tick();
      chk_flush("wrap 1", 1);
      chk_retire("wrap r62", 2'b01, 62, 0);
      tick();
      chk_flush("wrap 0", 0);
      check("wrap no retire", retire_valid, 0);
      tick();
      chk_flush("wrap 63", 63);
      settle();
      check("wrap occ end", occupancy, 0);
      check("wrap head", new_inst_id, 63);

      // Reset in the middle of a walk
      do_reset();
      dispatch(3);
      start_flush    = 1'b1;
      start_flush_to = 6'd0;
      tick();
      start_flush = 1'b0;
      rst         = 1'b0;
      tick();
      check("rstwalk flush", flush_valid, 0);
      check("rstwalk occ", occupancy, 0);
      check("rstwalk stall", stall_rename, 0);
      rst = 1'b1;
      tick();
      check("rstwalk after", flush_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rob_multi_retire.md
Name: rob_multi_retire

Overview:
- Next-generation reorder buffer: single-issue dispatch from the renamer, up to RETIRE_WIDTH in-order retirements per cycle, and a backward-walking flush.
- The flush restores rename mappings and frees the PRNs allocated by squashed instructions.
- Sits between renamer, functional units, LSU and remap file.
- Pointers carry a wrap bit, so full and empty are unambiguous and all 2^INST_ID_BITS entries are usable.

Parameters:
- INST_ID_BITS, 6, log2 of ROB depth; instruction ID width.
- PRN_BITS, 6, physical register number width.
- MAX_OPERANDS, 3, destination mappings tracked per instruction.
- FU_COUNT, 4, number of completion ports.
- RETIRE_WIDTH, 2, maximum retirements per cycle (1..4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
- inst_valid  in  1  renamer has an instruction
- inst_ready  out  1  = rst && !start_flush && !flushing && count<DEPTH (combinational)
- pc  in  64  instruction PC
- mapping_inputs_valid  in  1 x MAX_OPERANDS  mapping written by this instruction
- mapping_inputs_arn  in  6 x MAX_OPERANDS  architectural register
- mapping_inputs_prn  in  PRN_BITS x MAX_OPERANDS  previous (overwritten) PRN
- mapping_new_prn  in  PRN_BITS x MAX_OPERANDS  newly allocated PRN
- new_inst_id  out  INST_ID_BITS  head index (combinational); valid while inst_ready
- fu_out_inst_valid  in  1 x FU_COUNT  completion strobe
- fu_out_inst_ids  in  INST_ID_BITS x FU_COUNT  completing ID
- retire_valid  out  1 x RETIRE_WIDTH  lane retires (registered)
- retire_inst_id  out  INST_ID_BITS x RETIRE_WIDTH  retiring ID
- freed_prns_valid  out  1 x (RETIRE_WIDTH*MAX_OPERANDS)  old PRN freed at retire
- freed_prns  out  PRN_BITS x (RETIRE_WIDTH*MAX_OPERANDS)
- start_flush  in  1  squash start_flush_to and everything younger
- start_flush_to  in  INST_ID_BITS  oldest ID to squash
- flush_valid  out  1  one entry squashed this cycle (to LSU and issue queues)
- flush_inst_id  out  INST_ID_BITS  squashed ID
- reset_valid  out  1 x MAX_OPERANDS  remap-file restore
- arn_reset  out  6 x MAX_OPERANDS
- prn_reset  out  PRN_BITS x MAX_OPERANDS  restored (old) PRN
- flush_free_valid  out  1 x MAX_OPERANDS  new PRN of a squashed entry returned to the free list
- flush_free_prn  out  PRN_BITS x MAX_OPERANDS
- stall_rename  out  1  = start_flush || flushing
- occupancy  out  INST_ID_BITS+1  registered entry count

Behaviour:
- Reset: head, tail, occupancy = 0; flushing = 0; all valid outputs 0; all ID/PRN outputs 0; all entry states ISSUED.
- Entry states: ISSUED, COMMITTED.
- Dispatch: inst_valid && inst_ready writes entry[head] as ISSUED and advances head.
- Completion: a strobe whose ID lies in [tail, head) sets the entry COMMITTED next edge. IDs outside that range are ignored. Multiple ports naming the same ID is legal.
- Retire:
  - Lane k is valid iff entries tail..tail+k are all COMMITTED, inside [tail, head), and not in the flush range.
  - Outputs are registered: an entry committed at edge N can retire at edge N+1.
  - Tail advances by the number of valid lanes.
  - Lanes are contiguous from lane 0.
  - freed_prns is indexed lane*MAX_OPERANDS+op and copies the stored old-mapping valid bits.
- Flush FSM, IDLE -> WALK -> IDLE:
  - On start_flush in IDLE with target in [tail, head): set ptr=head-1, flush_to=target, go to WALK. A target outside the range is ignored.
  - Each WALK cycle emits flush_valid/flush_inst_id = ptr, reset_* = old mappings of entry[ptr], and flush_free_* = new PRNs of entry[ptr] (all registered). Then ptr decrements.
  - When ptr==flush_to has been emitted, set head=flush_to and return to IDLE.
  - A walk of N entries takes N cycles. Rename resumes the cycle after stall_rename drops.
  - start_flush during WALK with a strictly older in-range target updates flush_to. An equal or younger target is ignored. The walk never revisits entries.
  - Retirement continues during WALK for entries older than flush_to. Retirement never enters the flush range.
  - Completions for squashed IDs arriving after the walk are the issue logic's responsibility; downstream must drop ops on flush_valid.
- Wrap-around: pointers are INST_ID_BITS+1 wide. Index = low bits. Age comparisons use (id - tail) mod DEPTH.
- Reset mid-walk aborts the walk with no further outputs.

Decomposition:
- rob_pkg holds: the entry state enum, the rob_entry_t struct (state, pc, per-operand valid/arn/old_prn/new_prn), and the rob_age_lt function.
- Sub-module rob_retire_select: combinational leading-ones count over RETIRE_WIDTH entry states from tail, capped by occupancy and the flush boundary.

Test Plan:
- Fill/drain: dispatch 64 with no completions -> inst_ready=0 and occupancy=64. Complete ID 0 -> retire lane0 ID 0, occupancy 63, inst_ready=1.
- Multi-retire: dispatch 0..4, complete all at one edge -> next cycle lanes retire IDs 0,1; following cycle IDs 2,3; then ID 4 alone.
- Out-of-order completion: complete ID 2 before IDs 0 and 1 -> no retire until ID 0 commits; ID 2 never retires before ID 1.
- Flush: head=10, start_flush_to=6 -> flush_valid for IDs 9,8,7,6 on consecutive cycles with matching reset/flush_free values; head=6; stall_rename high for 5 cycles.
- Nested flush: during the walk above, start_flush_to=4 at ptr 8 -> walk continues to ID 4; a later start_flush_to=7 is ignored.
- Wrap: tail=62, dispatch 4 (IDs 62,63,0,1), flush to 63 -> IDs 1,0,63 squashed in that order; retire of 62 is unaffected.
